// File: rtl/fft_frame_source.sv
// Frame source for the FFT datapath: host fills an N-entry sample buffer, then
// i_start streams it out in natural order over a valid/ready interface.
module fft_frame_source #(
  parameter int LOG2N = 4,
  parameter int DW    = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [LOG2N-1:0]  i_wr_addr,
  input  logic [2*DW-1:0]   i_wr_data,
  input  logic              i_start,
  output logic [2*DW-1:0]   o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_data_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N:0] LAST_IDX = (LOG2N+1)'(N - 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_e;

  state_e            state_q;
  logic [LOG2N:0]    idx_q;
  logic [2*DW-1:0]   mem_q [N];
  logic [2*DW-1:0]   rd_data_q;

  logic              fire;
  logic              wr_ok;
  logic              rd_en_d;
  logic [LOG2N-1:0]  rd_addr_d;
  logic [LOG2N:0]    idx_inc;

  assign fire    = o_data_valid && i_data_ready;
  assign wr_ok   = i_wr_en && (state_q == IDLE || state_q == DONE);
  assign idx_inc = idx_q + (LOG2N+1)'(1);
  assign o_data  = rd_data_q;

  // Read address 0 is fetched in PREFETCH, after any write coincident with
  // i_start has landed; later reads advance only on a fire.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    if (state_q == PREFETCH) begin
      rd_en_d = 1'b1;
    end else if (state_q == STREAM && fire && idx_q != LAST_IDX) begin
      rd_en_d   = 1'b1;
      rd_addr_d = idx_inc[LOG2N-1:0];
    end
  end

  // Buffer and its registered read port carry no reset: contents survive.
  always_ff @(posedge i_clk) begin
    if (wr_ok)   mem_q[i_wr_addr] <= i_wr_data;
    if (rd_en_d) rd_data_q        <= mem_q[rd_addr_d];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state_q <= PREFETCH;
            idx_q   <= '0;
            o_busy  <= 1'b1;
          end
        end
        PREFETCH: begin
          state_q      <= STREAM;
          o_data_valid <= 1'b1;
          o_data_last  <= (N == 1);
        end
        STREAM: begin
          if (fire) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= DONE;
              o_data_valid <= 1'b0;
              o_data_last  <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b1;
            end else begin
              idx_q       <= idx_inc;
              o_data_last <= (idx_inc == LAST_IDX);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          o_done  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed bench for fft_frame_source: streaming, backpressure, ignored
// requests, mid-frame reset, long stall and start-with-write.
module tb_fft_frame_source;
  localparam int LOG2N = 4;
  localparam int DW    = 24;
  localparam int N     = 1 << LOG2N;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_wr_en;
  logic [LOG2N-1:0]  i_wr_addr;
  logic [2*DW-1:0]   i_wr_data;
  logic              i_start;
  logic [2*DW-1:0]   o_data;
  logic              o_data_valid;
  logic              i_data_ready;
  logic              o_data_last;
  logic              o_busy;
  logic              o_done;

  always #5 i_clk = ~i_clk;

  fft_frame_source #(.LOG2N(LOG2N), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .o_data(o_data),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_data_last(o_data_last), .o_busy(o_busy), .o_done(o_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2*DW-1:0] exp_mem [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Called just after a rising edge; leaves the same phase.
  task automatic write_mem(input int a, input logic [2*DW-1:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = LOG2N'(a);
    i_wr_data = d;
    @(posedge i_clk); #1;
    i_wr_en   = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: ready low 50 cycles;
  // 3: write mem[3] and re-start mid-frame; 4: start with write to address 0.
  task automatic run_frame(input int mode);
    int k = 0;
    int first_v = -1;
    int done_c = -1;
    int last_fire = -1;
    int busy_n = 0;
    logic [2*DW-1:0] pd = '0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      i_start = (c == 0);
      i_wr_en = 1'b0;
      if (mode == 4 && c == 0) begin
        i_wr_en = 1'b1; i_wr_addr = '0; i_wr_data = 48'h000001_000002;
      end
      if (mode == 3 && c == 3) begin
        i_wr_en = 1'b1; i_wr_addr = 4'd3; i_wr_data = 48'hFFFFFF_FFFFFF; i_start = 1'b1;
      end
      case (mode)
        1:       i_data_ready = (c % 4 == 0) || (c % 4 == 3);
        2:       i_data_ready = (c > 50);
        default: i_data_ready = 1'b1;
      endcase
      @(negedge i_clk);
      if (o_busy) busy_n++;
      if (o_data_valid && first_v < 0) begin
        first_v = c;
        chk("first_valid_cycle", 64'(c), 64'd2);
      end
      if (pv && !pr) begin
        chk("stall_data", o_data, pd);
        chk("stall_valid", o_data_valid, 1'b1);
        chk("stall_last", o_data_last, pl);
      end
      if (o_data_valid && i_data_ready) begin
        chk("fire_data", o_data, exp_mem[k % N]);
        chk("fire_last", o_data_last, k == N - 1);
        last_fire = c;
        k++;
      end
      if (o_done) begin
        done_c = c;
        chk("done_busy", o_busy, 1'b0);
        chk("done_valid", o_data_valid, 1'b0);
        break;
      end
      pv = o_data_valid; pr = i_data_ready; pd = o_data; pl = o_data_last;
      @(posedge i_clk); #1;
    end
    chk("fire_count", 64'(k), 64'(N));
    chk("done_after_last", 64'(done_c), 64'(last_fire + 1));
    chk("busy_cycles", 64'(busy_n), 64'(done_c - 1));
    if (mode == 0) chk("done_cycle", 64'(done_c), 64'(N + 2));
    @(posedge i_clk); #1;
    i_start = 1'b0; i_wr_en = 1'b0; i_data_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      chk("idle_valid", o_data_valid, 1'b0);
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_done", o_done, 1'b0);
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    int fires;
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 1'b0; i_data_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", o_data_valid, 1'b0);
    chk("rst_last", o_data_last, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      exp_mem[k] = {24'(k + 100), 24'(k)};
      write_mem(k, exp_mem[k]);
    end

    run_frame(0);
    run_frame(1);
    run_frame(3);
    run_frame(0);

    // Reset one cycle after the 5th fire; partial frame must be abandoned.
    fires = 0;
    i_data_ready = 1'b1;
    i_start = 1'b1;
    for (int c = 0; c < 40 && fires < 5; c++) begin
      @(negedge i_clk);
      if (o_data_valid && i_data_ready) fires++;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    chk("rst_mid_fires", 64'(fires), 64'd5);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      chk("midrst_valid", o_data_valid, 1'b0);
      chk("midrst_busy", o_busy, 1'b0);
      chk("midrst_done", o_done, 1'b0);
      chk("midrst_last", o_data_last, 1'b0);
      @(posedge i_clk); #1;
    end
    run_frame(0);

    run_frame(2);

    exp_mem[0] = 48'h000001_000002;
    run_frame(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
